// File: rtl/hcordic_exp_pipe_if.sv
// ---------------------------------------------------------------------------
// hcordic_exp_pipe_if
// Streaming port bundle for the hyperbolic CORDIC exponent pipeline.
//   ce        : pipeline advance enable (0 = every register holds)
//   in_valid  : z_in carries a real angle this cycle
//   z_in      : signed fixed-point angle
//   out_valid : x_out/y_out/z_out (and exp_out) carry a finished result
//   x_out     : cosh(z)
//   y_out     : sinh(z)
//   z_out     : residual angle, ~0 when converged
//   exp_out   : e^z = cosh + sinh (only when CORDIC_EXP_SUM_EN is defined)
// Modports: slave = the pipeline, master = whatever feeds and drains it.
// ---------------------------------------------------------------------------
interface hcordic_exp_pipe_if #(
  parameter int WIDTH = 32
);
  logic                    ce;
  logic                    in_valid;
  logic signed [WIDTH-1:0] z_in;
  logic                    out_valid;
  logic signed [WIDTH-1:0] x_out;
  logic signed [WIDTH-1:0] y_out;
  logic signed [WIDTH-1:0] z_out;
`ifdef CORDIC_EXP_SUM_EN
  logic signed [WIDTH-1:0] exp_out;

  modport slave (
    input  ce, in_valid, z_in,
    output out_valid, x_out, y_out, z_out, exp_out
  );

  modport master (
    output ce, in_valid, z_in,
    input  out_valid, x_out, y_out, z_out, exp_out
  );
`else
  modport slave (
    input  ce, in_valid, z_in,
    output out_valid, x_out, y_out, z_out
  );

  modport master (
    output ce, in_valid, z_in,
    input  out_valid, x_out, y_out, z_out
  );
`endif
endinterface

// File: rtl/hcordic_exp_pipe.sv
// ---------------------------------------------------------------------------
// hcordic_exp_pipe
// Fully pipelined hyperbolic CORDIC in rotation mode. Each valid angle z
// yields cosh(z), sinh(z) and the residual angle; one result per enabled
// cycle. Stage 0 captures the angle and seeds x with 1/K_h, then STAGES
// shift-add iterations follow (index sequence 1,2,3,4,4,5..13,13,14,..).
//
// Parameters
//   WIDTH  : signed datapath width of x/y/z (16..40)
//   FRAC   : fraction bits, Q(WIDTH-FRAC).FRAC, FRAC <= 24
//   STAGES : number of iteration stages including repeats (8..24)
//
// Ports
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset, dominates ce
//   bus   : hcordic_exp_pipe_if.slave (ce, in_valid, z_in in;
//           out_valid, x_out, y_out, z_out[, exp_out] out)
//
// Optional feature macro: CORDIC_EXP_SUM_EN
//   Defined   : one extra registered stage produces exp_out = x + y and
//               delays the other outputs with it (latency STAGES+2).
//   Undefined : no exp_out, outputs come straight from the last stage
//               (latency STAGES+1).
// ---------------------------------------------------------------------------
module hcordic_exp_pipe #(
  parameter int WIDTH  = 32,
  parameter int FRAC   = 24,
  parameter int STAGES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hcordic_exp_pipe_if.slave    bus
);

  // Shift amount used by iteration stage k. Indices 4 and 13 are
  // executed twice, which is what makes the hyperbolic iteration converge.
  function automatic int iter_shift(input int k);
    if (k < 4) begin
      return k + 1;
    end else if (k < 14) begin
      return k;
    end else begin
      return k - 1;
    end
  endfunction

  // atanh(2^-i) in Q8.24, rounded to nearest, then truncated to QFRAC.
  function automatic logic signed [WIDTH-1:0] atanh_const(input int i);
    logic signed [47:0] q;
    case (i)
      1:       q = 48'sd9215828;
      2:       q = 48'sd4285116;
      3:       q = 48'sd2108178;
      4:       q = 48'sd1049945;
      5:       q = 48'sd524459;
      6:       q = 48'sd262165;
      7:       q = 48'sd131075;
      8:       q = 48'sd65536;
      9:       q = 48'sd32768;
      10:      q = 48'sd16384;
      11:      q = 48'sd8192;
      12:      q = 48'sd4096;
      13:      q = 48'sd2048;
      14:      q = 48'sd1024;
      15:      q = 48'sd512;
      16:      q = 48'sd256;
      17:      q = 48'sd128;
      18:      q = 48'sd64;
      19:      q = 48'sd32;
      20:      q = 48'sd16;
      21:      q = 48'sd8;
      22:      q = 48'sd4;
      default: q = 48'sd0;
    endcase
    q = q >>> (24 - FRAC);
    return q[WIDTH-1:0];
  endfunction

  // 1/K_h = 1.2074970677 is held in Q8.24 and rounded to nearest when
  // the datapath carries fewer fraction bits.
  function automatic logic signed [WIDTH-1:0] x_init();
    logic signed [47:0] q;
    q = 48'sd20258439;
    if (FRAC < 24) begin
      q = q + (48'sd1 <<< (23 - FRAC));
    end
    q = q >>> (24 - FRAC);
    return q[WIDTH-1:0];
  endfunction

  localparam logic signed [WIDTH-1:0] X_INIT = x_init();

  // Element 0 is the input register, element STAGES the last iteration.
  logic signed [WIDTH-1:0] xs [0:STAGES];
  logic signed [WIDTH-1:0] ys [0:STAGES];
  logic signed [WIDTH-1:0] zs [0:STAGES];
  logic        [STAGES:0]  vs;

  // Whole iteration pipeline. Data registers load on every enabled edge
  // whether or not the slot is valid; the valid bit rides alongside.
  // A negative residual angle rotates the other way (d = -1).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k <= STAGES; k++) begin
        xs[k] <= '0;
        ys[k] <= '0;
        zs[k] <= '0;
      end
      vs <= '0;
    end else if (bus.ce) begin
      xs[0] <= X_INIT;
      ys[0] <= '0;
      zs[0] <= bus.z_in;
      vs[0] <= bus.in_valid;
      for (int k = 0; k < STAGES; k++) begin
        if (zs[k][WIDTH-1]) begin
          xs[k+1] <= xs[k] - (ys[k] >>> iter_shift(k));
          ys[k+1] <= ys[k] - (xs[k] >>> iter_shift(k));
          zs[k+1] <= zs[k] + atanh_const(iter_shift(k));
        end else begin
          xs[k+1] <= xs[k] + (ys[k] >>> iter_shift(k));
          ys[k+1] <= ys[k] + (xs[k] >>> iter_shift(k));
          zs[k+1] <= zs[k] - atanh_const(iter_shift(k));
        end
        vs[k+1] <= vs[k];
      end
    end
  end

`ifdef CORDIC_EXP_SUM_EN
  logic signed [WIDTH-1:0] out_x;
  logic signed [WIDTH-1:0] out_y;
  logic signed [WIDTH-1:0] out_z;
  logic signed [WIDTH-1:0] out_e;
  logic                    out_v;

  // Sum stage: e^z = cosh + sinh, wrapping on overflow. The other outputs
  // pass through the same register so everything stays aligned.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_x <= '0;
      out_y <= '0;
      out_z <= '0;
      out_e <= '0;
      out_v <= 1'b0;
    end else if (bus.ce) begin
      out_x <= xs[STAGES];
      out_y <= ys[STAGES];
      out_z <= zs[STAGES];
      out_e <= xs[STAGES] + ys[STAGES];
      out_v <= vs[STAGES];
    end
  end

  assign bus.x_out     = out_x;
  assign bus.y_out     = out_y;
  assign bus.z_out     = out_z;
  assign bus.exp_out   = out_e;
  assign bus.out_valid = out_v;
`else
  assign bus.x_out     = xs[STAGES];
  assign bus.y_out     = ys[STAGES];
  assign bus.z_out     = zs[STAGES];
  assign bus.out_valid = vs[STAGES];
`endif

endmodule

// File: tb/tb_hcordic_exp_pipe.sv
// ---------------------------------------------------------------------------
// tb_hcordic_exp_pipe
// Directed bench for hcordic_exp_pipe at default parameters (Q8.24, 16
// stages). Expected cosh/sinh values are hand-computed constants in Q24.
// A monitor pairs every accepted input with the result it should produce
// and checks value and latency in enabled edges.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hcordic_exp_pipe;

  localparam int WIDTH  = 32;
  localparam int FRAC   = 24;
  localparam int STAGES = 16;
`ifdef CORDIC_EXP_SUM_EN
  localparam int LAT = STAGES + 2;
`else
  localparam int LAT = STAGES + 1;
`endif
  // The last iteration uses i=14, so the residual angle can be up to about
  // 2^-14; scaled by cosh(1) this bounds the result error near 2^-13.
  localparam longint TOL = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  hcordic_exp_pipe_if #(.WIDTH(WIDTH)) bus ();

  hcordic_exp_pipe #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC),
    .STAGES(STAGES)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int outCount = 0;
  int enEdges = 0;
  longint curX = 0;
  longint curY = 0;

  typedef struct {
    longint x;
    longint y;
    int     tag;
  } exp_t;
  exp_t pend[$];

  // One comparison: counts it and reports it when outside tolerance.
  task automatic checkOutput(input string tag, input longint observed,
                             input longint expected, input longint tol);
    longint diff;
    checks++;
    diff = observed - expected;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (tol %0d)", tag, observed, expected, tol);
    end
  endtask

  // Angle table in Q24 with hand-computed cosh/sinh in Q24.
  function automatic void vecFor(input int idx, output longint z,
                                 output longint x, output longint y);
    case (idx)
      0:       begin z = 0;         x = 16777216; y = 0;         end
      1:       begin z = 4194304;   x = 17304240; y = 4238131;   end
      2:       begin z = 8388608;   x = 18918424; y = 8742529;   end
      3:       begin z = 16777216;  x = 25888597; y = 19716604;  end
      4:       begin z = -4194304;  x = 17304240; y = -4238131;  end
      5:       begin z = -8388608;  x = 18918424; y = -8742529;  end
      default: begin z = -16777216; x = 25888597; y = -19716604; end
    endcase
  endfunction

  // Drive one cycle of input, then step to just after the next edge.
  task automatic applyStimulus(input int idx, input logic valid, input logic ceVal);
    longint z, x, y;
    vecFor(idx, z, x, y);
    bus.z_in     = WIDTH'(z);
    bus.in_valid = valid;
    bus.ce       = ceVal;
    curX = x;
    curY = y;
    @(posedge clk);
    #1;
  endtask

  // Idle until every accepted sample has come out, then a few more cycles
  // so a stray out_valid would still be seen.
  task automatic waitDrain();
    int n;
    n = 0;
    while (pend.size() != 0 && n < 200) begin
      applyStimulus(0, 1'b0, 1'b1);
      n++;
    end
    if (pend.size() != 0) begin
      checkOutput("drain_timeout", pend.size(), 0, 0);
      pend.delete();
    end
    for (int c = 0; c < LAT + 4; c++) applyStimulus(0, 1'b0, 1'b1);
  endtask

  // Scoreboard monitor: logs accepted inputs on enabled edges and checks
  // the matching result when out_valid rises after an enabled edge.
  always @(posedge clk) begin
    logic ceS, rS, vS;
    exp_t e;
    ceS = bus.ce;
    rS  = rst_n;
    vS  = bus.in_valid;
    if (!rS) begin
      pend.delete();
    end else if (ceS) begin
      if (vS) begin
        e.x = curX;
        e.y = curY;
        e.tag = enEdges;
        pend.push_back(e);
      end
      enEdges++;
    end
    #1;
    if (rS && ceS && bus.out_valid) begin
      outCount++;
      if (pend.size() == 0) begin
        checkOutput("unexp_valid", 1, 0, 0);
      end else begin
        e = pend.pop_front();
        checkOutput("latency", enEdges - e.tag, LAT, 0);
        checkOutput("x_out", longint'(bus.x_out), e.x, TOL);
        checkOutput("y_out", longint'(bus.y_out), e.y, TOL);
        checkOutput("z_res", longint'(bus.z_out), 0, TOL);
`ifdef CORDIC_EXP_SUM_EN
        checkOutput("exp_out", longint'(bus.exp_out), e.x + e.y, 2 * TOL);
`endif
      end
    end
  end

  initial begin
    #1000000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int base;
    int p;
    logic ceVal;
    logic [15:0] cePat;
    cePat = 16'b1001_1011_0100_1101;

    bus.ce       = 1'b1;
    bus.in_valid = 1'b1;
    bus.z_in     = 32'h0080_0000;
    rst_n        = 1'b0;

    $display("[TB] reset held with in_valid high");
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      checkOutput("rst_valid", bus.out_valid, 0, 0);
      checkOutput("rst_x", longint'(bus.x_out), 0, 0);
      checkOutput("rst_y", longint'(bus.y_out), 0, 0);
      checkOutput("rst_z", longint'(bus.z_out), 0, 0);
    end
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    bus.z_in     = '0;
    for (int c = 0; c < STAGES; c++) begin
      @(posedge clk);
      #1;
      checkOutput("post_rst_valid", bus.out_valid, 0, 0);
      checkOutput("post_rst_x", longint'(bus.x_out), 0, 0);
      checkOutput("post_rst_y", longint'(bus.y_out), 0, 0);
    end

    $display("[TB] single angles 0, 0.5, -1.0");
    base = outCount;
    applyStimulus(0, 1'b1, 1'b1);
    waitDrain();
    checkOutput("single_count", outCount - base, 1, 0);
    applyStimulus(2, 1'b1, 1'b1);
    waitDrain();
    applyStimulus(6, 1'b1, 1'b1);
    waitDrain();

    $display("[TB] back-to-back stream of 20");
    base = outCount;
    for (int n = 0; n < 20; n++) applyStimulus(n % 7, 1'b1, 1'b1);
    waitDrain();
    checkOutput("stream_count", outCount - base, 20, 0);

    $display("[TB] stream of 20 with ce toggling");
    base = outCount;
    p = 0;
    for (int n = 0; n < 20; n++) begin
      do begin
        ceVal = cePat[p % 16];
        p++;
        applyStimulus(n % 7, 1'b1, ceVal);
      end while (!ceVal);
    end
    waitDrain();
    checkOutput("ce_stream_count", outCount - base, 20, 0);

    $display("[TB] reset pulse with 8 in flight");
    base = outCount;
    for (int n = 0; n < 8; n++) applyStimulus(n % 7, 1'b1, 1'b1);
    rst_n = 1'b0;
    applyStimulus(3, 1'b1, 1'b1);
    checkOutput("midrst_valid", bus.out_valid, 0, 0);
    checkOutput("midrst_x", longint'(bus.x_out), 0, 0);
    rst_n = 1'b1;
    applyStimulus(2, 1'b1, 1'b1);
    waitDrain();
    checkOutput("midrst_count", outCount - base, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
